// File: rtl/multicycle_ctrl.sv
// Multicycle controller: fixed 5-state IF/ID/EX/MEM/WB sequence.
// The instruction is latched into IR on leaving IF and every output is
// decoded from state and IR only; zero qualifies pcSrc during WB.
module multicycle_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        zero,
  output logic [2:0]  state,
  output logic        aluSrc,
  output logic [3:0]  aluCtrl,
  output logic        memRead,
  output logic        memWrite,
  output logic        memToReg,
  output logic        regWrite,
  output logic        loadPC,
  output logic        pcSrc
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    C_ILL, C_R, C_I, C_LD, C_ST, C_BR
  } cls_t;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SRL = 4'b1000;
  localparam logic [3:0] ALU_SLL = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1010;

  state_t      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic        alu_src_q, alu_src_d;
  logic [3:0]  alu_ctrl_q, alu_ctrl_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic        mem_to_reg_q, mem_to_reg_d;
  logic        reg_write_q, reg_write_d;
  logic        load_pc_q, load_pc_d;
  logic        branch_q, branch_d;
  cls_t        cls_d;

  // Only opcode, funct3 and funct7[5] matter to this controller.
  logic unused_ir;
  assign unused_ir = ^{ir_q[31], ir_q[29:15], ir_q[11:7]};

  function automatic cls_t classify(input logic [6:0] op, input logic [2:0] f3);
    cls_t c;
    c = C_ILL;
    case (op)
      OP_R:    c = C_R;
      OP_I:    c = C_I;
      OP_LD:   c = C_LD;
      OP_ST:   c = C_ST;
      OP_BR:   c = (f3 == 3'b000) ? C_BR : C_ILL;
      default: c = C_ILL;
    endcase
    return c;
  endfunction

  function automatic logic [3:0] alu_dec(input cls_t c, input logic [2:0] f3,
                                         input logic f7b5);
    logic [3:0] a;
    a = ALU_AND;
    case (c)
      C_LD, C_ST: a = ALU_ADD;
      C_BR:       a = ALU_SUB;
      C_R, C_I: begin
        case (f3)
          3'b000:  a = (c == C_R && f7b5) ? ALU_SUB : ALU_ADD;
          3'b111:  a = ALU_AND;
          3'b110:  a = ALU_OR;
          3'b100:  a = ALU_XOR;
          3'b010:  a = ALU_SLT;
          3'b001:  a = ALU_SLL;
          3'b101:  a = f7b5 ? ALU_SRA : ALU_SRL;
          default: a = ALU_AND;
        endcase
      end
      default:    a = ALU_AND;
    endcase
    return a;
  endfunction

  // Next state, IR capture and next-cycle output decode. Outputs are
  // computed from the upcoming state/IR so they can be registered.
  always_comb begin
    ir_d = (state_q == S_IF) ? instr : ir_q;
    case (state_q)
      S_IF:    state_d = S_ID;
      S_ID:    state_d = S_EX;
      S_EX:    state_d = S_MEM;
      S_MEM:   state_d = S_WB;
      S_WB:    state_d = S_IF;
      default: state_d = S_IF;
    endcase
    cls_d        = classify(ir_d[6:0], ir_d[14:12]);
    alu_src_d    = (cls_d == C_I) || (cls_d == C_LD) || (cls_d == C_ST);
    alu_ctrl_d   = alu_dec(cls_d, ir_d[14:12], ir_d[30]);
    mem_to_reg_d = (cls_d == C_LD);
    mem_read_d   = (state_d == S_MEM) && (cls_d == C_LD);
    mem_write_d  = (state_d == S_MEM) && (cls_d == C_ST);
    reg_write_d  = (state_d == S_WB) &&
                   ((cls_d == C_R) || (cls_d == C_I) || (cls_d == C_LD));
    load_pc_d    = (state_d == S_WB);
    branch_d     = (state_d == S_WB) && (cls_d == C_BR);
  end

  // State, IR and registered outputs; reset clears all strobes at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IF;
      ir_q         <= '0;
      alu_src_q    <= 1'b0;
      alu_ctrl_q   <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      reg_write_q  <= 1'b0;
      load_pc_q    <= 1'b0;
      branch_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      ir_q         <= ir_d;
      alu_src_q    <= alu_src_d;
      alu_ctrl_q   <= alu_ctrl_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      reg_write_q  <= reg_write_d;
      load_pc_q    <= load_pc_d;
      branch_q     <= branch_d;
    end
  end

  assign state    = state_q;
  assign aluSrc   = alu_src_q;
  assign aluCtrl  = alu_ctrl_q;
  assign memRead  = mem_read_q;
  assign memWrite = mem_write_q;
  assign memToReg = mem_to_reg_q;
  assign regWrite = reg_write_q;
  assign loadPC   = load_pc_q;
  // zero is only meaningful in WB; branch_q already implies WB.
  assign pcSrc    = branch_q & zero;

endmodule
